// File: rtl/counter_pkg.sv
// Shared types and width helpers for the prescaled start/done counter.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

    // Bits needed to hold 0..max_n (at least one bit).
    function automatic int ctr_size(input int max_n);
        int w;
        w = $clog2(max_n + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Bits needed to hold 0..max_presc (at least one bit).
    function automatic int presc_size(input int max_presc);
        int w;
        w = $clog2(max_presc + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick on every (presc_lat+1)-th enabled cycle.
// With presc_lat = 0 the tick is continuous while enable is high.
module tick_gen #(
    parameter int PRESC_SIZE = 1
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [PRESC_SIZE-1:0] presc_lat,
    output logic                  tick
);

    logic [PRESC_SIZE-1:0] presc_cnt_reg;

    assign tick = enable & (presc_cnt_reg == presc_lat);

    // Prescale counter: frozen while disabled, wraps to 0 on each tick.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            presc_cnt_reg <= '0;
        end else if (clear) begin
            presc_cnt_reg <= '0;
        end else if (tick) begin
            presc_cnt_reg <= '0;
        end else if (enable) begin
            presc_cnt_reg <= presc_cnt_reg + PRESC_SIZE'(1);
        end
    end

endmodule

// File: rtl/prescaled_counter.sv
// Programmable event counter with prescaler, one-shot/auto-reload,
// pause/resume and abort. Counts ticks from 0 up to a latched target.
module prescaled_counter
    import counter_pkg::*;
#(
    parameter int  MAX_N      = 9,
    parameter int  MAX_PRESC  = 0,
    localparam int CTR_SIZE   = ctr_size(MAX_N),
    localparam int PRESC_SIZE = presc_size(MAX_PRESC)
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  pause,
    input  logic                  mode,
    input  logic [CTR_SIZE-1:0]   n_val,
    input  logic [PRESC_SIZE-1:0] presc_val,
    output logic [CTR_SIZE-1:0]   ctr_val,
    output logic                  busy,
    output logic                  done_sig
);

    localparam logic [CTR_SIZE-1:0]   N_LIMIT = CTR_SIZE'(MAX_N);
    localparam logic [PRESC_SIZE-1:0] P_LIMIT = PRESC_SIZE'(MAX_PRESC);

    state_t                state_reg, state_next;
    logic [CTR_SIZE-1:0]   ctr_reg, ctr_next, ctr_inc;
    logic [CTR_SIZE-1:0]   n_lat_reg;
    logic [PRESC_SIZE-1:0] presc_lat_reg;
    logic                  mode_lat_reg;
    logic                  done_reg, done_next;
    logic                  busy_reg;
    logic                  load, presc_clear, cnt_enable, tick;

    // stop beats start; a start in the same cycle as stop is dropped.
    assign load        = start & ~stop;
    assign presc_clear = stop | start | (state_reg == IDLE);
    // A zero target finishes without ticking, so the prescaler stays idle.
    assign cnt_enable  = (state_reg != IDLE) & ~stop & ~start & ~pause
                         & (n_lat_reg != '0);
    assign ctr_inc     = ctr_reg + CTR_SIZE'(1);

    tick_gen #(
        .PRESC_SIZE(PRESC_SIZE)
    ) u_tick_gen (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .clear    (presc_clear),
        .enable   (cnt_enable),
        .presc_lat(presc_lat_reg),
        .tick     (tick)
    );

    // State register.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state, next count and done pulse; priority stop > start > pause.
    always_comb begin
        state_next = state_reg;
        ctr_next   = ctr_reg;
        done_next  = 1'b0;
        if (stop) begin
            if (state_reg != IDLE) begin
                state_next = IDLE;
                ctr_next   = '0;
            end
        end else if (start) begin
            ctr_next   = '0;
            state_next = pause ? PAUSED : RUN;
        end else if (state_reg != IDLE) begin
            if (pause) begin
                state_next = PAUSED;
            end else begin
                state_next = RUN;
                if (n_lat_reg == '0) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                    ctr_next   = '0;
                end else if (tick) begin
                    if (ctr_reg == n_lat_reg) begin
                        // Only reachable in auto-reload: wrap after the target.
                        ctr_next = '0;
                    end else begin
                        ctr_next = ctr_inc;
                        if (ctr_inc == n_lat_reg) begin
                            done_next = 1'b1;
                            if (mode_lat_reg == MODE_ONESHOT) begin
                                state_next = IDLE;
                            end
                        end
                    end
                end
            end
        end
    end

    // Count, done pulse and busy flag, all registered.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            ctr_reg  <= '0;
            done_reg <= 1'b0;
            busy_reg <= 1'b0;
        end else begin
            ctr_reg  <= ctr_next;
            done_reg <= done_next;
            busy_reg <= (state_next != IDLE);
        end
    end

    // Latch the clamped target, prescale and mode on an accepted start.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            n_lat_reg     <= '0;
            presc_lat_reg <= '0;
            mode_lat_reg  <= MODE_ONESHOT;
        end else if (load) begin
            n_lat_reg     <= (32'(n_val) > MAX_N) ? N_LIMIT : n_val;
            presc_lat_reg <= (32'(presc_val) > MAX_PRESC) ? P_LIMIT : presc_val;
            mode_lat_reg  <= mode;
        end
    end

    assign ctr_val  = ctr_reg;
    assign busy     = busy_reg;
    assign done_sig = done_reg;

endmodule

// File: tb/tb_prescaled_counter.sv
// Self-checking bench for prescaled_counter (MAX_N=9, MAX_PRESC=3).
module tb_prescaled_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stop, pause, mode;
    logic [3:0] n_val;
    logic [1:0] presc_val;
    logic [3:0] ctr_val;
    logic       busy, done_sig;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: counts enabled cycles since start and derives the
    // tick number and count value arithmetically.
    int m_ctr, m_n, m_p, m_e;
    bit m_busy, m_done, m_mode;

    always #5 clk = ~clk;

    prescaled_counter #(
        .MAX_N    (9),
        .MAX_PRESC(3)
    ) dut (
        .sys_clk  (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .n_val    (n_val),
        .presc_val(presc_val),
        .ctr_val  (ctr_val),
        .busy     (busy),
        .done_sig (done_sig)
    );

    task automatic model_reset();
        m_ctr = 0; m_n = 0; m_p = 0; m_e = 0;
        m_busy = 0; m_done = 0; m_mode = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge.
    task automatic step(input bit st, input bit sp, input bit pa,
                        input int nv, input int pv, input bit md);
        int k;
        start = st; stop = sp; pause = pa;
        n_val = 4'(nv); presc_val = 2'(pv); mode = md;
        @(posedge clk);
        cyc++;
        m_done = 0;
        if (sp) begin
            if (m_busy) begin
                m_busy = 0;
                m_ctr  = 0;
            end
        end else if (st) begin
            m_n = (nv > 9) ? 9 : nv;
            m_p = (pv > 3) ? 3 : pv;
            m_mode = md; m_e = 0; m_busy = 1; m_ctr = 0;
        end else if (m_busy && !pa) begin
            if (m_n == 0) begin
                m_done = 1; m_busy = 0; m_ctr = 0;
            end else begin
                m_e++;
                if (m_e % (m_p + 1) == 0) begin
                    k = m_e / (m_p + 1);
                    if (m_mode) begin
                        m_ctr = k % (m_n + 1);
                        if (m_ctr == m_n) m_done = 1;
                    end else begin
                        m_ctr = k;
                        if (k == m_n) begin
                            m_done = 1;
                            m_busy = 0;
                        end
                    end
                end
            end
        end
        #1;
        start = 0; stop = 0;
        $display("cyc=%0d st=%b sp=%b pa=%b ctr=%0d busy=%b done=%b", cyc, st, sp, pa,
                 ctr_val, busy, done_sig);
    endtask

    task automatic test_reset();
        rst = 1; start = 0; stop = 0; pause = 0; mode = 0; n_val = 0; presc_val = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (ctr_val !== 4'd0 || busy !== 1'b0 || done_sig !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state got ctr=%0d busy=%b done=%b expected 0/0/0",
                     ctr_val, busy, done_sig);
        end
        rst = 0;
        step(0, 0, 1, 5, 1, 0);   // pause alone in IDLE does nothing
        n_vec++;
        if (ctr_val !== 4'd0 || busy !== 1'b0 || done_sig !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got ctr=%0d busy=%b done=%b expected 0/0/0",
                     ctr_val, busy, done_sig);
        end
    endtask

    task automatic test_oneshot();
        step(1, 0, 0, 7, 0, 0);
        n_vec++;
        if (ctr_val !== 4'd0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL oneshot_start got ctr=%0d busy=%b expected ctr=0 busy=1", ctr_val, busy);
        end
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 0, 7, 0, 0);
            n_vec++;
            if (ctr_val !== 4'((i < 7) ? i : 7) || busy !== (i < 7) || done_sig !== (i == 7)) begin
                n_err++;
                $display("FAIL oneshot i=%0d got ctr=%0d busy=%b done=%b expected ctr=%0d busy=%b done=%b",
                         i, ctr_val, busy, done_sig, (i < 7) ? i : 7, (i < 7), (i == 7));
            end
        end
    endtask

    task automatic test_reload();
        step(1, 0, 0, 3, 2, 1);
        for (int i = 1; i <= 26; i++) begin
            step(0, 0, 0, 3, 2, 1);
            n_vec++;
            if (ctr_val !== 4'((i / 3) % 4) || busy !== 1'b1 || done_sig !== (i == 9 || i == 21)) begin
                n_err++;
                $display("FAIL reload i=%0d got ctr=%0d busy=%b done=%b expected ctr=%0d busy=1 done=%b",
                         i, ctr_val, busy, done_sig, (i / 3) % 4, (i == 9 || i == 21));
            end
        end
        step(0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_pause();
        bit pa;
        step(1, 0, 0, 9, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            pa = (i >= 5 && i <= 9);
            step(0, 0, pa, 9, 0, 0);
            n_vec++;
            if (ctr_val !== 4'(m_ctr) || busy !== m_busy || done_sig !== m_done
                || done_sig !== (i == 14)) begin
                n_err++;
                $display("FAIL pause i=%0d got ctr=%0d busy=%b done=%b expected ctr=%0d busy=%b done=%b",
                         i, ctr_val, busy, done_sig, m_ctr, m_busy, m_done);
            end
        end
    endtask

    task automatic test_stop();
        step(1, 0, 0, 9, 0, 0);
        repeat (5) step(0, 0, 0, 9, 0, 0);
        n_vec++;
        if (ctr_val !== 4'd5) begin
            n_err++;
            $display("FAIL stop_pre got ctr=%0d expected 5", ctr_val);
        end
        step(0, 1, 0, 9, 0, 0);
        n_vec++;
        if (ctr_val !== 4'd0 || busy !== 1'b0 || done_sig !== 1'b0) begin
            n_err++;
            $display("FAIL stop_abort got ctr=%0d busy=%b done=%b expected 0/0/0",
                     ctr_val, busy, done_sig);
        end
        step(1, 1, 0, 4, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (ctr_val !== 4'd0 || busy !== 1'b0 || done_sig !== 1'b0) begin
                n_err++;
                $display("FAIL stop_start_same i=%0d got ctr=%0d busy=%b done=%b expected 0/0/0",
                         i, ctr_val, busy, done_sig);
            end
            step(0, 0, 0, 4, 0, 0);
        end
        // Abort from PAUSED
        step(1, 0, 1, 6, 1, 0);
        step(0, 0, 1, 6, 1, 0);
        step(0, 1, 1, 6, 1, 0);
        n_vec++;
        if (ctr_val !== 4'd0 || busy !== 1'b0 || done_sig !== 1'b0 || m_busy) begin
            n_err++;
            $display("FAIL stop_paused got ctr=%0d busy=%b done=%b expected 0/0/0",
                     ctr_val, busy, done_sig);
        end
        pause = 0;
    endtask

    task automatic test_async_reset();
        step(1, 0, 0, 9, 1, 1);
        repeat (6) step(0, 0, 0, 9, 1, 1);
        n_vec++;
        if (ctr_val !== 4'd3 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL arst_pre got ctr=%0d busy=%b expected ctr=3 busy=1", ctr_val, busy);
        end
        #2 rst = 1;
        #1;
        n_vec++;
        if (ctr_val !== 4'd0 || busy !== 1'b0 || done_sig !== 1'b0) begin
            n_err++;
            $display("FAIL arst_immediate got ctr=%0d busy=%b done=%b expected 0/0/0",
                     ctr_val, busy, done_sig);
        end
        #2 rst = 0;
        model_reset();
        step(1, 0, 0, 0, 2, 1);
        n_vec++;
        if (busy !== 1'b1 || done_sig !== 1'b0) begin
            n_err++;
            $display("FAIL zero_start got busy=%b done=%b expected busy=1 done=0", busy, done_sig);
        end
        step(0, 0, 0, 0, 2, 1);
        n_vec++;
        if (ctr_val !== 4'd0 || busy !== 1'b0 || done_sig !== 1'b1) begin
            n_err++;
            $display("FAIL zero_done got ctr=%0d busy=%b done=%b expected 0/0/1",
                     ctr_val, busy, done_sig);
        end
        step(0, 0, 0, 0, 2, 1);
        n_vec++;
        if (done_sig !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL zero_after got busy=%b done=%b expected 0/0", busy, done_sig);
        end
    endtask

    task automatic test_clamp_restart();
        step(1, 0, 0, 12, 0, 0);
        repeat (6) step(0, 0, 0, 12, 0, 0);
        n_vec++;
        if (ctr_val !== 4'd6 || done_sig !== 1'b0) begin
            n_err++;
            $display("FAIL restart_pre got ctr=%0d done=%b expected ctr=6 done=0", ctr_val, done_sig);
        end
        step(1, 0, 0, 12, 0, 0);
        n_vec++;
        if (ctr_val !== 4'd0 || busy !== 1'b1 || done_sig !== 1'b0) begin
            n_err++;
            $display("FAIL restart got ctr=%0d busy=%b done=%b expected 0/1/0", ctr_val, busy, done_sig);
        end
        for (int i = 1; i <= 11; i++) begin
            step(0, 0, 0, 12, 0, 0);
            n_vec++;
            if (ctr_val !== 4'((i < 9) ? i : 9) || busy !== (i < 9) || done_sig !== (i == 9)) begin
                n_err++;
                $display("FAIL clamp i=%0d got ctr=%0d busy=%b done=%b expected ctr=%0d busy=%b done=%b",
                         i, ctr_val, busy, done_sig, (i < 9) ? i : 9, (i < 9), (i == 9));
            end
        end
    endtask

    task automatic test_random();
        bit st, sp, pa, md;
        int nv, pv;
        for (int i = 0; i < 600; i++) begin
            st = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 39) == 0);
            pa = ($urandom_range(0, 7) == 0);
            md = 1'($urandom_range(0, 1));
            nv = $urandom_range(0, 15);
            pv = $urandom_range(0, 3);
            step(st, sp, pa, nv, pv, md);
            n_vec++;
            if (ctr_val !== 4'(m_ctr) || busy !== m_busy || done_sig !== m_done) begin
                n_err++;
                $display("FAIL random i=%0d got ctr=%0d busy=%b done=%b expected ctr=%0d busy=%b done=%b",
                         i, ctr_val, busy, done_sig, m_ctr, m_busy, m_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_pause();
        test_stop();
        test_async_reset();
        test_clamp_restart();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
